aging_priority_arbiter: RTL and testbench
=========================================

Name: aging_priority_arbiter

Overview:
Static-priority arbiter with per-channel aging and a programmable runtime timeout. Channel 0 has the highest priority. Channels 1..SIZE-1 count the cycles they wait while denied. Once a channel's wait reaches the timeout it is "timed out", and all timed-out channels are served round-robin ahead of the static order, so no timed-out channel can starve another. Grants are qualified by a ready signal from the shared resource. The block sits in front of any shared resource (bus, port, buffer) that needs bounded-latency arbitration.

Parameters:
SIZE, 4, number of request channels (>=2).
TIMEOUT_WIDTH, 4, width of the wait counters and of timeout_value; counters saturate at 2^TIMEOUT_WIDTH-1.

Ports:
clock  input  1  clock.
resetn  input  1  asynchronous active-low reset.
requests  input  SIZE  request per channel; bit 0 has the highest static priority.
ready  input  1  resource accepts the current grant this cycle.
timeout_value  input  TIMEOUT_WIDTH  wait threshold in cycles; 0 disables aging.
grant  output  SIZE  one-hot or zero grant, combinational.
grant_timeout  output  1  current grant was selected by the aging path.
timed_out  output  SIZE  per-channel timed-out flags; bit 0 is always 0.

Behaviour:
- Reset is asynchronous (resetn, active-low); clocking is on clock.
- State:
  - wait_count[i] for i = 1..SIZE-1, TIMEOUT_WIDTH bits, reset value 0.
  - rr_pointer, clog2(SIZE) bits, reset value 1.
  - No other state.
- Outputs with ready=0 or requests=0: grant=0, grant_timeout=0.
- timed_out[i] = requests[i] & (timeout_value!=0) & (wait_count[i] >= timeout_value), for i >= 1.
  - Combinational, so a change to timeout_value takes effect in the same cycle.
  - Changing timeout_value never clears counters.
- Grant selection (combinational, zero-cycle latency, only when ready=1):
  - If timed_out is non-zero: grant the first set timed_out bit at index >= rr_pointer, wrapping from SIZE-1 back to 1; grant_timeout=1.
  - Otherwise: grant the lowest-index set request bit; grant_timeout=0.
- "Accepted" means grant[i] & ready.
- wait_count[i] next-state, highest precedence first:
  1. requests[i]=0: clear to 0 (a withdrawn request loses its age).
  2. Grant accepted for channel i: clear to 0.
  3. requests[i]=1 and not accepted (denied, or ready=0): increment, saturating at all-ones.
- rr_pointer: on an accepted grant with grant_timeout=1 to channel k, load k+1, wrapping SIZE to 1. Index 0 is never loaded. Otherwise hold.
- Aging arithmetic: with timeout_value=T, a channel requesting continuously and always denied is timed out in its (T+1)th requesting cycle.
  - T=1 means it is timed out from the second cycle.
  - T = 2^TIMEOUT_WIDTH-1 is reachable because the counter saturates rather than wrapping.
- Channel 0 never ages; it wins whenever no channel is timed out.
- Simultaneous events:
  - A request that drops in the same cycle it is granted still gets its counter cleared.
  - The pointer moves only on an accepted aging grant.
- Reset mid-operation: counters go to 0 and the pointer to 1 immediately. grant reverts to static priority in the same cycle (it is combinational from requests).
- Invariants (the bench asserts these):
  - grant is one-hot or zero.
  - grant is a subset of requests.
  - grant=0 whenever ready=0.
  - timed_out[0]=0.

Test Plan:
1. Static priority: SIZE=4, timeout_value=0, ready=1, requests=1110 then 1100 then 1000 -> grant 0010, 0100, 1000; grant_timeout=0 throughout.
2. Aging plus round-robin: timeout_value=3, ready=1, requests=1111 held from cycle 0.
   - Cycles 0-2: grant 0001.
   - Cycle 3: timed_out=1110, grant 0010, grant_timeout=1.
   - Cycle 4: grant 0100. Cycle 5: grant 1000.
   - Cycle 6: grant 0001 (ch1 count=2).
   - Cycle 7: grant 0010.
3. Aging disabled then enabled: timeout_value=0, requests=1111 for 20 cycles -> grant always 0001, counters saturate at 15. Set timeout_value=15 -> same cycle timed_out=1110, grant 0010, grant_timeout=1.
4. Ready stall: timeout_value=3, requests=0110, ready=0 for 5 cycles.
   - During the stall: grant=0000; timed_out=0110 from cycle 3.
   - ready=1: grant 0010 with grant_timeout=1, then 0100 on the next cycle.
5. Withdrawal: timeout_value=4; ch2 requests alongside ch0 for 3 cycles (count=3), drops for 1 cycle, re-requests -> count restarts at 0; ch2 is not timed out until 4 further denied cycles.
6. Async reset: assert resetn low mid-scenario 2 while grant=0100 -> counters 0, rr_pointer 1, grant=0001 with no clock edge. Release -> aging restarts from 0.

Source files
------------

// File: rtl/aging_priority_arbiter.sv
// Static-priority arbiter with per-channel aging: channels waiting at least
// timeout_value cycles are served round-robin ahead of the static order.
module aging_priority_arbiter #(
    parameter int unsigned SIZE          = 4,
    parameter int unsigned TIMEOUT_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [SIZE-1:0]          requests,
    input  logic                     ready,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_value,
    output logic [SIZE-1:0]          grant,
    output logic                     grant_timeout,
    output logic [SIZE-1:0]          timed_out
);

    localparam int unsigned PTR_W = $clog2(SIZE);
    localparam int unsigned NCH   = SIZE - 1;
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = '1;

    logic [TIMEOUT_WIDTH-1:0] wait_count [1:SIZE-1];
    logic [PTR_W-1:0]         rr_pointer;
    logic [PTR_W-1:0]         rr_next;

    // A channel is timed out only while it is requesting and aging is enabled.
    always_comb begin
        timed_out = '0;
        for (int i = 1; i < SIZE; i++) begin
            timed_out[i] = requests[i] && (timeout_value != '0) &&
                           (wait_count[i] >= timeout_value);
        end
    end

    // Grant selection: round-robin among timed-out channels, else static priority.
    always_comb begin
        int unsigned pos;
        logic [PTR_W-1:0] sel;
        logic found;
        grant         = '0;
        grant_timeout = 1'b0;
        rr_next       = rr_pointer;
        found         = 1'b0;
        pos           = 0;
        sel           = '0;
        if (ready) begin
            if (timed_out != '0) begin
                for (int unsigned off = 0; off < NCH; off++) begin
                    pos = 32'(rr_pointer) - 1 + off;
                    if (pos >= NCH) pos = pos - NCH;
                    pos = pos + 1;
                    sel = PTR_W'(pos);
                    if (!found && timed_out[sel]) begin
                        found         = 1'b1;
                        grant[sel]    = 1'b1;
                        grant_timeout = 1'b1;
                        rr_next       = (pos == NCH) ? PTR_W'(1) : PTR_W'(pos + 1);
                    end
                end
            end else begin
                for (int i = 0; i < SIZE; i++) begin
                    if (!found && requests[i]) begin
                        found    = 1'b1;
                        grant[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Wait counters clear on withdrawal or acceptance, otherwise saturate upward.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < SIZE; i++) wait_count[i] <= '0;
            rr_pointer <= PTR_W'(1);
        end else begin
            for (int i = 1; i < SIZE; i++) begin
                if (!requests[i]) begin
                    wait_count[i] <= '0;
                end else if (grant[i] && ready) begin
                    wait_count[i] <= '0;
                end else if (wait_count[i] != CNT_MAX) begin
                    wait_count[i] <= wait_count[i] + TIMEOUT_WIDTH'(1);
                end
            end
            if (ready && grant_timeout) rr_pointer <= rr_next;
        end
    end

endmodule

// File: tb/tb_aging_priority_arbiter.sv
// Self-checking bench for aging_priority_arbiter: directed scenarios plus
// randomized traffic against an integer age/round-robin reference model.
module tb_aging_priority_arbiter;

    localparam int unsigned SIZE = 4;
    localparam int unsigned TW   = 4;
    localparam int          CMAX = 15;

    logic            clock;
    logic            resetn;
    logic [SIZE-1:0] requests;
    logic            ready;
    logic [TW-1:0]   timeout_value;
    logic [SIZE-1:0] grant;
    logic            grant_timeout;
    logic [SIZE-1:0] timed_out;

    int checks   = 0;
    int failures = 0;

    // reference model state: ages in plain integers, pointer as channel number
    int m_age [SIZE];
    int m_ptr;
    logic [SIZE-1:0] e_g;
    logic            e_gt;
    logic [SIZE-1:0] e_to;

    aging_priority_arbiter #(.SIZE(SIZE), .TIMEOUT_WIDTH(TW)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .requests      (requests),
        .ready         (ready),
        .timeout_value (timeout_value),
        .grant         (grant),
        .grant_timeout (grant_timeout),
        .timed_out     (timed_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model_reset();
        for (int i = 0; i < SIZE; i++) m_age[i] = 0;
        m_ptr = 1;
    endfunction

    function automatic void model_eval(input logic [SIZE-1:0] req, input logic rdy, input int tv);
        int c;
        e_to = '0;
        e_g  = '0;
        e_gt = 1'b0;
        for (int i = 1; i < SIZE; i++)
            if (req[i] && tv != 0 && m_age[i] >= tv) e_to[i] = 1'b1;
        if (rdy) begin
            if (e_to != '0) begin
                for (int n = 0; n < SIZE - 1; n++) begin
                    c = ((m_ptr - 1 + n) % (SIZE - 1)) + 1;
                    if (e_to[c]) begin
                        e_g[c] = 1'b1;
                        e_gt   = 1'b1;
                        break;
                    end
                end
            end else begin
                for (int i = 0; i < SIZE; i++) begin
                    if (req[i]) begin
                        e_g[i] = 1'b1;
                        break;
                    end
                end
            end
        end
    endfunction

    function automatic void model_step(input logic [SIZE-1:0] req, input logic rdy);
        for (int i = 1; i < SIZE; i++) begin
            if (!req[i])                m_age[i] = 0;
            else if (e_g[i] && rdy)     m_age[i] = 0;
            else if (m_age[i] < CMAX)   m_age[i] = m_age[i] + 1;
        end
        if (rdy && e_gt)
            for (int i = 1; i < SIZE; i++)
                if (e_g[i]) m_ptr = (i == SIZE - 1) ? 1 : i + 1;
    endfunction

    task automatic apply(input logic [SIZE-1:0] req, input logic rdy, input int tv);
        requests      = req;
        ready         = rdy;
        timeout_value = TW'(tv);
        #1;
        model_eval(req, rdy, tv);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(requests, ready);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        #3;
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        apply(4'b1111, 1'b1, 15);
        model_reset();
        model_eval(4'b1111, 1'b1, 15);
        checks++;
        if ({grant, grant_timeout, timed_out} !== {4'b0001, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL reset grant=%b gt=%b to=%b expected 0001 0 0000", grant, grant_timeout, timed_out);
        end
        #3;
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_static();
        logic [SIZE-1:0] reqs [5] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b1011};
        logic            rdys [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [SIZE-1:0] exps [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            apply(reqs[c], rdys[c], 0);
            checks++;
            if (grant !== exps[c] || grant_timeout !== 1'b0 || timed_out !== 4'b0000) begin
                failures++;
                $display("FAIL static cyc=%0d grant=%b gt=%b to=%b expected %b 0 0000", c, grant, grant_timeout, timed_out, exps[c]);
            end
            tick();
        end
    endtask

    task automatic test_aging();
        logic [SIZE-1:0] exps [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic            gts  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply(4'b1111, 1'b1, 3);
            checks++;
            if (grant !== exps[c] || grant_timeout !== gts[c] || grant !== e_g || timed_out !== e_to) begin
                failures++;
                $display("FAIL aging cyc=%0d grant=%b gt=%b to=%b expected %b %b %b", c, grant, grant_timeout, timed_out, exps[c], gts[c], e_to);
            end
            if (c == 3) begin
                checks++;
                if (timed_out !== 4'b1110) begin
                    failures++;
                    $display("FAIL aging_to cyc=3 to=%b expected 1110", timed_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_disabled();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            apply(4'b1111, 1'b1, 0);
            checks++;
            if (grant !== 4'b0001 || grant_timeout !== 1'b0 || timed_out !== 4'b0000) begin
                failures++;
                $display("FAIL disabled cyc=%0d grant=%b gt=%b to=%b expected 0001 0 0000", c, grant, grant_timeout, timed_out);
            end
            tick();
        end
        apply(4'b1111, 1'b1, 15);
        checks++;
        if (grant !== 4'b0010 || grant_timeout !== 1'b1 || timed_out !== 4'b1110) begin
            failures++;
            $display("FAIL enable15 grant=%b gt=%b to=%b expected 0010 1 1110", grant, grant_timeout, timed_out);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [SIZE-1:0] exp_to;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            apply(4'b0110, 1'b0, 3);
            exp_to = (c >= 3) ? 4'b0110 : 4'b0000;
            checks++;
            if (grant !== 4'b0000 || grant_timeout !== 1'b0 || timed_out !== exp_to) begin
                failures++;
                $display("FAIL stall cyc=%0d grant=%b gt=%b to=%b expected 0000 0 %b", c, grant, grant_timeout, timed_out, exp_to);
            end
            tick();
        end
        apply(4'b0110, 1'b1, 3);
        checks++;
        if (grant !== 4'b0010 || grant_timeout !== 1'b1) begin
            failures++;
            $display("FAIL stall_rel1 grant=%b gt=%b expected 0010 1", grant, grant_timeout);
        end
        tick();
        apply(4'b0110, 1'b1, 3);
        checks++;
        if (grant !== 4'b0100 || grant_timeout !== 1'b1) begin
            failures++;
            $display("FAIL stall_rel2 grant=%b gt=%b expected 0100 1", grant, grant_timeout);
        end
        tick();
    endtask

    task automatic test_withdraw();
        logic [SIZE-1:0] reqs [9] = '{4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
        logic [SIZE-1:0] exps [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
        logic [SIZE-1:0] tos  [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            apply(reqs[c], 1'b1, 4);
            checks++;
            if (grant !== exps[c] || timed_out !== tos[c] || grant_timeout !== (tos[c] != 0)) begin
                failures++;
                $display("FAIL withdraw cyc=%0d grant=%b gt=%b to=%b expected %b %b", c, grant, grant_timeout, timed_out, exps[c], tos[c]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(4'b1111, 1'b1, 3);
            tick();
        end
        apply(4'b1111, 1'b1, 3);
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL areset_pre grant=%b expected 0100", grant);
        end
        resetn = 1'b0;
        #1;
        model_reset();
        model_eval(4'b1111, 1'b1, 3);
        checks++;
        if (grant !== 4'b0001 || grant_timeout !== 1'b0 || timed_out !== 4'b0000) begin
            failures++;
            $display("FAIL areset grant=%b gt=%b to=%b expected 0001 0 0000", grant, grant_timeout, timed_out);
        end
        #2;
        resetn = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            apply(4'b1111, 1'b1, 3);
            checks++;
            if (grant !== ((c < 3) ? 4'b0001 : (c == 3 ? 4'b0010 : 4'b0100)) || grant !== e_g) begin
                failures++;
                $display("FAIL areset_post cyc=%0d grant=%b model=%b", c, grant, e_g);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [SIZE-1:0] req;
        logic            rdy;
        int              tv;
        do_reset();
        tv = 3;
        for (int c = 0; c < 400; c++) begin
            if (c % 25 == 0) tv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
            req = SIZE'($urandom);
            if ($urandom_range(0, 3) != 0) req[0] = 1'b0;
            rdy = ($urandom_range(0, 3) != 0);
            apply(req, rdy, tv);
            checks++;
            if ({grant, grant_timeout, timed_out} !== {e_g, e_gt, e_to}) begin
                failures++;
                $display("FAIL random cyc=%0d req=%b rdy=%b tv=%0d grant=%b gt=%b to=%b expected %b %b %b",
                         c, req, rdy, tv, grant, grant_timeout, timed_out, e_g, e_gt, e_to);
            end
            checks++;
            if (!$onehot0(grant) || (grant & ~req) != '0 || (!rdy && grant != '0) || timed_out[0] !== 1'b0) begin
                failures++;
                $display("FAIL invariant cyc=%0d req=%b rdy=%b grant=%b to=%b", c, req, rdy, grant, timed_out);
            end
            tick();
        end
    endtask

    initial begin
        resetn        = 1'b0;
        requests      = '0;
        ready         = 1'b0;
        timeout_value = '0;
        model_reset();
        @(posedge clock);
        #1;
        test_reset();
        test_static();
        test_aging();
        test_disabled();
        test_stall();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
